// File: rtl/ef_pkg.sv
// Shared state encoding, mode codes and W-bit extreme helpers for the extremum window sequencer.
`timescale 1ns/1ps
package ef_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_MEASURE = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_PUBLISH = 3'd4
    } ef_state_t;

    localparam logic [1:0] EF_MODE_A   = 2'b00;
    localparam logic [1:0] EF_MODE_B   = 2'b01;
    localparam logic [1:0] EF_MODE_ALT = 2'b10;

    localparam int unsigned EF_CNT_W = 32;

    // Most-positive / most-negative w-bit two's complement values, zero-extended to 32 bits.
    function automatic logic [31:0] ef_max_pos(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] ef_min_neg(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/ef_threshold_calc.sv
// Shrinks a [min, max] span around its centre by 2^shift and registers the saturated bounds.
`timescale 1ns/1ps
module ef_threshold_calc
    import ef_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_min,
    input  logic [W-1:0] i_max,
    input  logic [2:0]   i_shift,
    output logic [W-1:0] o_lo,
    output logic [W-1:0] o_hi
);

    localparam logic [W-1:0] MAX_POS = W'(ef_max_pos(W));
    localparam logic [W-1:0] MIN_NEG = W'(ef_min_neg(W));

    logic signed [W:0] w_min;
    logic signed [W:0] w_max;
    logic signed [W:0] w_center;
    logic signed [W:0] w_lo;
    logic signed [W:0] w_hi;

    // Overflow into the extra bit shows up as the top two bits disagreeing.
    function automatic logic [W-1:0] sat(input logic [W:0] v);
        if (v[W] != v[W-1]) begin
            return v[W] ? MIN_NEG : MAX_POS;
        end
        return v[W-1:0];
    endfunction

    always_comb begin
        w_min    = {i_min[W-1], i_min};
        w_max    = {i_max[W-1], i_max};
        w_center = (w_min + w_max) >>> 1;
        w_lo     = ((w_min - w_center) >>> i_shift) + w_center;
        w_hi     = ((w_max - w_center) >>> i_shift) + w_center;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_lo <= '0;
            o_hi <= '0;
        end else if (i_load) begin
            o_lo <= sat(w_lo);
            o_hi <= sat(w_hi);
        end
    end

endmodule

// File: rtl/extremum_window_sequencer.sv
// Runs min/max measurement windows on channel A/B of the ADC stream and publishes
// shrunk thresholds per channel through one shared threshold datapath.
`timescale 1ns/1ps
module extremum_window_sequencer
    import ef_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32
) (
    input  logic                          SYS_aclk,
    input  logic                          SYS_reset,
    input  logic                          EF_enable,
    input  logic                          EF_single,
    input  logic [1:0]                    EF_mode,
    input  logic [4:0]                    EF_log_count,
    input  logic [2:0]                    EF_shift,
    output logic [AXIS_TDATA_WIDTH/2-1:0] EF_lower_a,
    output logic [AXIS_TDATA_WIDTH/2-1:0] EF_upper_a,
    output logic [AXIS_TDATA_WIDTH/2-1:0] EF_lower_b,
    output logic [AXIS_TDATA_WIDTH/2-1:0] EF_upper_b,
    output logic                          EF_update_a,
    output logic                          EF_update_b,
    output logic                          EF_busy,
    input  logic                          S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
    output logic                          S_AXIS_tready
);

    localparam int unsigned W = AXIS_TDATA_WIDTH / 2;
    localparam logic [W-1:0] MAX_POS = W'(ef_max_pos(W));
    localparam logic [W-1:0] MIN_NEG = W'(ef_min_neg(W));

    ef_state_t r_state;
    ef_state_t w_state_nxt;

    logic                 r_en_q;
    logic                 r_arm;
    logic                 r_ptr_b;
    logic                 r_sel_b;
    logic [EF_CNT_W-1:0]  r_cnt;
    logic [4:0]           r_log;
    logic [2:0]           r_shift;
    logic [1:0]           r_mode;
    logic signed [W-1:0]  r_min;
    logic signed [W-1:0]  r_max;
    logic [W-1:0]         r_lower_a;
    logic [W-1:0]         r_upper_a;
    logic [W-1:0]         r_lower_b;
    logic [W-1:0]         r_upper_b;
    logic                 r_update_a;
    logic                 r_update_b;
    logic                 r_busy;
    logic                 r_tready;

    logic                 w_rise;
    logic                 w_stop;
    logic                 w_leave_idle;
    logic                 w_clear;
    logic                 w_beat;
    logic                 w_load;
    logic                 w_publish;
    logic [EF_CNT_W-1:0]  w_cnt_inc;
    logic [EF_CNT_W-1:0]  w_target;
    logic signed [W-1:0]  w_sample;
    logic [W-1:0]         w_lo;
    logic [W-1:0]         w_hi;

    assign w_rise       = EF_enable & ~r_en_q;
    assign w_cnt_inc    = r_cnt + EF_CNT_W'(1);
    assign w_target     = EF_CNT_W'(1) << r_log;
    assign w_sample     = r_sel_b ? S_AXIS_tdata[2*W-1:W] : S_AXIS_tdata[W-1:0];
    assign w_leave_idle = (r_state == ST_IDLE) && (w_state_nxt != ST_IDLE);
    // Stop after this window when disabled, or single-shot is done (a full A,B pair in alternate mode).
    assign w_stop       = !EF_enable || (EF_single && ((r_mode != EF_MODE_ALT) || r_ptr_b));

    always_ff @(posedge SYS_aclk) begin
        if (SYS_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_beat      = 1'b0;
        w_load      = 1'b0;
        w_publish   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (EF_enable && (!EF_single || r_arm || w_rise)) w_state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_clear     = 1'b1;
                w_state_nxt = ST_MEASURE;
            end
            ST_MEASURE: begin
                w_beat = S_AXIS_tvalid;
                if (S_AXIS_tvalid && (w_cnt_inc == w_target)) w_state_nxt = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                w_load      = 1'b1;
                w_state_nxt = ST_PUBLISH;
            end
            ST_PUBLISH: begin
                w_publish   = 1'b1;
                w_state_nxt = w_stop ? ST_IDLE : ST_CLEAR;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge SYS_aclk) begin
        if (SYS_reset) begin
            r_en_q     <= 1'b0;
            r_arm      <= 1'b0;
            r_ptr_b    <= 1'b0;
            r_sel_b    <= 1'b0;
            r_cnt      <= '0;
            r_log      <= '0;
            r_shift    <= '0;
            r_mode     <= EF_MODE_A;
            r_min      <= MAX_POS;
            r_max      <= MIN_NEG;
            r_lower_a  <= '0;
            r_upper_a  <= '0;
            r_lower_b  <= '0;
            r_upper_b  <= '0;
            r_update_a <= 1'b0;
            r_update_b <= 1'b0;
            r_busy     <= 1'b0;
            r_tready   <= 1'b1;
        end else begin
            r_en_q     <= EF_enable;
            r_arm      <= (r_arm | w_rise) & ~w_leave_idle;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_tready   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_CLEAR) ||
                          (w_state_nxt == ST_MEASURE);
            r_update_a <= 1'b0;
            r_update_b <= 1'b0;
            if (w_clear) begin
                r_log   <= EF_log_count;
                r_shift <= EF_shift;
                r_mode  <= EF_mode;
                r_sel_b <= (EF_mode == EF_MODE_B) || ((EF_mode == EF_MODE_ALT) && r_ptr_b);
                r_min   <= MAX_POS;
                r_max   <= MIN_NEG;
                r_cnt   <= '0;
            end
            if (w_beat) begin
                if (w_sample < r_min) r_min <= w_sample;
                if (w_sample > r_max) r_max <= w_sample;
                r_cnt <= w_cnt_inc;
            end
            if (w_publish) begin
                if (r_sel_b) begin
                    r_lower_b  <= w_lo;
                    r_upper_b  <= w_hi;
                    r_update_b <= 1'b1;
                end else begin
                    r_lower_a  <= w_lo;
                    r_upper_a  <= w_hi;
                    r_update_a <= 1'b1;
                end
                if (r_mode == EF_MODE_ALT) r_ptr_b <= ~r_ptr_b;
            end
        end
    end

    ef_threshold_calc #(.W(W)) u_calc (
        .clk     (SYS_aclk),
        .rst     (SYS_reset),
        .i_load  (w_load),
        .i_min   (r_min),
        .i_max   (r_max),
        .i_shift (r_shift),
        .o_lo    (w_lo),
        .o_hi    (w_hi)
    );

    assign EF_lower_a    = r_lower_a;
    assign EF_upper_a    = r_upper_a;
    assign EF_lower_b    = r_lower_b;
    assign EF_upper_b    = r_upper_b;
    assign EF_update_a   = r_update_a;
    assign EF_update_b   = r_update_b;
    assign EF_busy       = r_busy;
    assign S_AXIS_tready = r_tready;

endmodule
